// File: rtl/uart_pkg.sv
// Shared constants and launch-FSM encoding for the UART loopback byte FIFO.
package uart_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } launch_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage: synchronous write port, asynchronous read at rd_addr.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between UART RX and TX with a launch FSM issuing one TX strobe per byte.
// Optional saturating drop counter enabled by defining UART_FIFO_DROP_CNT_EN.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Wr_DV,
  input  logic [7:0]       i_Wr_Byte,
  input  logic             i_TX_Active,
  input  logic             i_TX_Done,
  output logic             o_TX_DV,
  output logic [7:0]       o_TX_Byte,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Empty,
  output logic             o_Full,
  output logic             o_Overflow,
  output logic [7:0]       o_Drop_Count
);

  localparam int PTR_W = $clog2(DEPTH);

  launch_state_t     state_reg, state_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              empty_reg, full_reg;
  logic              overflow_reg;
  logic [7:0]        tx_byte_reg;
  logic [7:0]        rd_data;
  logic              pop, push, drop;

  // Pop eligibility uses the registered empty flag, so a push into an empty
  // FIFO can never be popped in the same cycle.
  assign pop  = (state_reg == ST_IDLE) && !empty_reg && !i_TX_Active;
  assign push = i_Wr_DV && (!full_reg || pop);
  assign drop = i_Wr_DV && full_reg && !pop;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (i_Clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (i_Wr_Byte),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pop) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_BUSY;
      ST_BUSY:   if (i_TX_Done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Decoded from the state register only, so the strobe falls with reset.
  always_comb begin
    o_TX_DV = 1'b0;
    if (state_reg == ST_LAUNCH) begin
      o_TX_DV = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      tx_byte_reg  <= 8'h00;
    end else begin
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == CNT_W'(DEPTH));
      overflow_reg <= drop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        tx_byte_reg <= rd_data;
      end
    end
  end

`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      drop_cnt_reg <= 8'h00;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign o_Drop_Count = drop_cnt_reg;
`else
  assign o_Drop_Count = 8'h00;
`endif

  assign o_TX_Byte  = tx_byte_reg;
  assign o_Count    = count_reg;
  assign o_Empty    = empty_reg;
  assign o_Full     = full_reg;
  assign o_Overflow = overflow_reg;

endmodule
